// File: rtl/decode_fetch_ctrl_if.sv
// rtl/decode_fetch_ctrl_if.sv - fetch bus and decoder window signals for decode_fetch_ctrl
interface decode_fetch_ctrl_if;
    logic          fetch_req;
    logic [63:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [63:0]   fetch_rdata;
    logic [0:119]  dec_window;
    logic          dec_valid;
    logic [63:0]   dec_pc;
    logic          dec_consume;
    logic [3:0]    dec_byte_incr;
    logic          redirect;
    logic [63:0]   redirect_pc;
    logic          consume_err;

    modport master (
        output fetch_req, fetch_addr, dec_window, dec_valid, dec_pc, consume_err,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, dec_consume, dec_byte_incr,
               redirect, redirect_pc
    );

    modport slave (
        input  fetch_req, fetch_addr, dec_window, dec_valid, dec_pc, consume_err,
        output fetch_gnt, fetch_rvalid, fetch_rdata, dec_consume, dec_byte_incr,
               redirect, redirect_pc
    );
endinterface

// File: rtl/decode_fetch_ctrl.sv
// rtl/decode_fetch_ctrl.sv - instruction-byte queue and aligned fetch sequencer for the decoder
module decode_fetch_ctrl #(
    parameter int          BUF_BYTES = 32,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic               clk,
    input  logic               reset_n,
    decode_fetch_ctrl_if.master bus
);
    localparam int AW = $clog2(BUF_BYTES);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [7:0]      buf_q [BUF_BYTES];
    logic [7:0]      buf_d [BUF_BYTES];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [63:0]     dec_pc_q, dec_pc_d;
    logic [63:0]     fetch_addr_q, fetch_addr_d;
    logic [2:0]      skip_q, skip_d;
    logic            fetch_req_q, fetch_req_d;
    logic            consume_err_q, consume_err_d;

    logic            dec_valid;
    logic            consume_ok;
    logic            has_space;
    logic [3:0]      fill_n;
    logic [AW-1:0]   widx;
    logic [0:119]    win;

    // Empty queue already forces count below 15; the drain term keeps the intent explicit.
    assign dec_valid = (count_q >= CW'(15)) && !(state_q == F_DRAIN && count_q == '0);

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        dec_pc_d      = dec_pc_q;
        fetch_addr_d  = fetch_addr_q;
        skip_d        = skip_q;
        consume_err_d = consume_err_q;
        fill_n        = 4'd0;
        widx          = '0;
        has_space     = 1'b0;

        consume_ok = bus.dec_consume && dec_valid && (bus.dec_byte_incr != 4'd0) && !bus.redirect;
        if (bus.dec_consume && (!dec_valid || bus.dec_byte_incr == 4'd0))
            consume_err_d = 1'b1;

        if (consume_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(bus.dec_byte_incr);
            count_d  = count_q - CW'(bus.dec_byte_incr);
            dec_pc_d = dec_pc_q + 64'(bus.dec_byte_incr);
        end

        if (state_q == F_WAIT && bus.fetch_rvalid && !bus.redirect) begin
            for (int i = 0; i < 8; i++) begin
                if (3'(i) >= skip_q) begin
                    widx        = wr_ptr_q + AW'(i) - AW'(skip_q);
                    buf_d[widx] = bus.fetch_rdata[i*8 +: 8];
                end
            end
            fill_n       = 4'd8 - {1'b0, skip_q};
            wr_ptr_d     = wr_ptr_q + AW'(fill_n);
            count_d      = count_d + CW'(fill_n);
            skip_d       = 3'd0;
            fetch_addr_d = fetch_addr_q + 64'd8;
        end

        has_space = count_d <= CW'(BUF_BYTES - 8);

        case (state_q)
            F_IDLE:  if (has_space) state_d = F_REQ;
            F_REQ:   if (bus.fetch_gnt) state_d = F_WAIT;
            F_WAIT:  if (bus.fetch_rvalid) state_d = has_space ? F_REQ : F_IDLE;
            F_DRAIN: if (bus.fetch_rvalid) state_d = F_REQ;
            default: state_d = F_IDLE;
        endcase

        // A grant in the redirect cycle still leaves a response in flight that must be dropped.
        if (bus.redirect) begin
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            dec_pc_d     = bus.redirect_pc;
            skip_d       = bus.redirect_pc[2:0];
            fetch_addr_d = {bus.redirect_pc[63:3], 3'b000};
            if (state_q == F_WAIT || (state_q == F_DRAIN && !bus.fetch_rvalid) ||
                (state_q == F_REQ && bus.fetch_gnt))
                state_d = F_DRAIN;
            else
                state_d = F_REQ;
        end

        fetch_req_d = (state_d == F_REQ);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= F_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            dec_pc_q      <= RESET_PC;
            fetch_addr_q  <= {RESET_PC[63:3], 3'b000};
            skip_q        <= RESET_PC[2:0];
            fetch_req_q   <= 1'b0;
            consume_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            dec_pc_q      <= dec_pc_d;
            fetch_addr_q  <= fetch_addr_d;
            skip_q        <= skip_d;
            fetch_req_q   <= fetch_req_d;
            consume_err_q <= consume_err_d;
        end
    end

    // Byte storage carries no reset: only bytes below count are ever meaningful.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_comb begin
        win = '0;
        for (int k = 0; k < 15; k++)
            win[k*8 +: 8] = buf_q[rd_ptr_q + AW'(k)];
    end

    assign bus.fetch_req   = fetch_req_q;
    assign bus.fetch_addr  = fetch_addr_q;
    assign bus.dec_window  = win;
    assign bus.dec_valid   = dec_valid;
    assign bus.dec_pc      = dec_pc_q;
    assign bus.consume_err = consume_err_q;
endmodule
